// File: rtl/fx2_fifo_sched.sv
// FX2 slave-FIFO scheduler: EP2 host-to-FPGA reads, EP6 FPGA-to-host writes.
// Define FX2_SCHED_PKTEND_EN to commit short IN packets after an idle timeout.
module fx2_fifo_sched #(
  parameter int BURST_MAX = 64,
  parameter int PKT_WORDS = 512,
  parameter int TIMEOUT   = 1000
) (
  input  logic       IFCLK,
  input  logic       RST,
  input  logic [7:0] FDI,
  output logic [7:0] FDO,
  output logic       FDS,
  output logic       SLRD,
  output logic       SLWR,
  output logic       SLOE,
  output logic [1:0] ADDR,
  output logic       PKTEND,
  input  logic       FLAGB,
  input  logic       FLAGC,
  output logic [7:0] h2f_data,
  output logic       h2f_valid,
  input  logic       h2f_ready,
  input  logic [7:0] f2h_data,
  input  logic       f2h_valid,
  output logic       f2h_ready,
  output logic       busy
);

  if (BURST_MAX < 1 || BURST_MAX > 255 || TIMEOUT < 1 ||
      TIMEOUT > 65535 || PKT_WORDS < 2) begin : g_bad_cfg
    $error("fx2_fifo_sched: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE, RD_SETUP, READ, WR_SETUP, WRITE
`ifdef FX2_SCHED_PKTEND_EN
    , PK_SETUP, PKT
`endif
  } state_t;

  state_t     state, nxt;
  logic [7:0] burst_cnt;
  logic       last_wr;
  logic       req_rd, req_wr;
  logic       rd_xfer, wr_xfer;
  logic       burst_last;
  logic       nxt_rd, nxt_wr;

  assign req_rd     = FLAGB & h2f_ready;
  assign req_wr     = f2h_valid & FLAGC;
  assign rd_xfer    = (state == READ) & req_rd;
  assign wr_xfer    = (state == WRITE) & req_wr;
  assign burst_last = burst_cnt == 8'(BURST_MAX - 1);

  assign SLRD      = ~rd_xfer;
  assign SLWR      = ~wr_xfer;
  assign h2f_valid = rd_xfer;
  assign f2h_ready = wr_xfer;
  assign h2f_data  = FDI;
  assign FDO       = f2h_data;
  assign busy      = state != IDLE;

`ifdef FX2_SCHED_PKTEND_EN
  localparam int PW = $clog2(PKT_WORDS);

  logic [PW-1:0] pkt_cnt, pkt_nxt;
  logic [15:0]   to_cnt;
  logic          pend;
  logic          to_hit;

  assign pkt_nxt = (pkt_cnt == PW'(PKT_WORDS - 1)) ? '0 : pkt_cnt + 1'b1;
  assign to_hit  = to_cnt == 16'(TIMEOUT);
  assign PKTEND  = state != PKT;

  always_ff @(posedge IFCLK) begin
    if (RST) begin
      pkt_cnt <= '0;
      pend    <= 1'b0;
      to_cnt  <= '0;
    end else if (wr_xfer) begin
      pkt_cnt <= pkt_nxt;
      pend    <= pkt_nxt != '0;
      to_cnt  <= '0;
    end else if (state == PKT) begin
      pkt_cnt <= '0;
      pend    <= 1'b0;
      to_cnt  <= '0;
    end else if (pend && !to_hit) begin
      to_cnt  <= to_cnt + 16'd1;
    end
  end
`else
  assign PKTEND = 1'b1;
`endif

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (req_rd && (!req_wr || last_wr)) nxt = RD_SETUP;
        else if (req_wr)                    nxt = WR_SETUP;
`ifdef FX2_SCHED_PKTEND_EN
        // a stale partial packet outranks new reads
        if (pend && to_hit && !req_wr)      nxt = PK_SETUP;
`endif
      end
      RD_SETUP: nxt = READ;
      READ: begin
        if (!FLAGB || (rd_xfer && burst_last) || (!h2f_ready && req_wr))
          nxt = IDLE;
      end
      WR_SETUP: nxt = WRITE;
      WRITE: begin
        if (!FLAGC || !f2h_valid || burst_last) nxt = IDLE;
      end
`ifdef FX2_SCHED_PKTEND_EN
      PK_SETUP: nxt = PKT;
      PKT:      nxt = IDLE;
`endif
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    nxt_rd = (nxt == RD_SETUP) || (nxt == READ);
    nxt_wr = (nxt == WR_SETUP) || (nxt == WRITE);
`ifdef FX2_SCHED_PKTEND_EN
    nxt_wr = nxt_wr || (nxt == PK_SETUP) || (nxt == PKT);
`endif
  end

  // bus controls are registered off the next state so FDS and SLOE switch together
  always_ff @(posedge IFCLK) begin
    if (RST) begin
      state     <= IDLE;
      ADDR      <= 2'b00;
      FDS       <= 1'b0;
      SLOE      <= 1'b1;
      burst_cnt <= '0;
      last_wr   <= 1'b1;
    end else begin
      state <= nxt;
      ADDR  <= nxt_wr ? 2'b10 : 2'b00;
      FDS   <= nxt_wr;
      SLOE  <= ~nxt_rd;
      if (state == IDLE)
        burst_cnt <= '0;
      else if (rd_xfer || wr_xfer)
        burst_cnt <= burst_cnt + 8'd1;
      if (state == IDLE && nxt == RD_SETUP) last_wr <= 1'b0;
      if (state == IDLE && nxt == WR_SETUP) last_wr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fx2_fifo_sched.sv
// Directed bench for fx2_fifo_sched: vector table plus burst/timeout sequences.
// Builds with or without FX2_SCHED_PKTEND_EN.
module tb_fx2_fifo_sched;

  logic       IFCLK = 1'b0;
  logic       RST;
  logic [7:0] FDI, FDO;
  logic       FDS, SLRD, SLWR, SLOE, PKTEND;
  logic [1:0] ADDR;
  logic       FLAGB, FLAGC;
  logic [7:0] h2f_data, f2h_data;
  logic       h2f_valid, h2f_ready;
  logic       f2h_valid, f2h_ready;
  logic       busy;

  fx2_fifo_sched dut (
    .IFCLK(IFCLK), .RST(RST), .FDI(FDI), .FDO(FDO), .FDS(FDS),
    .SLRD(SLRD), .SLWR(SLWR), .SLOE(SLOE), .ADDR(ADDR),
    .PKTEND(PKTEND), .FLAGB(FLAGB), .FLAGC(FLAGC),
    .h2f_data(h2f_data), .h2f_valid(h2f_valid), .h2f_ready(h2f_ready),
    .f2h_data(f2h_data), .f2h_valid(f2h_valid), .f2h_ready(f2h_ready),
    .busy(busy)
  );

  always #5 IFCLK = ~IFCLK;

  int cyc = 0;
  always @(posedge IFCLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge IFCLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    FLAGB = 0; FLAGC = 0; h2f_ready = 0; f2h_valid = 0;
    FDI = 8'h00; f2h_data = 8'h00;
    tick();
    tick();
    RST = 1'b0;
  endtask

  // count write strobes up to n, then drop f2h_valid (or FLAGC) after the last
  task automatic write_n(input int n, input int budget, input bit drop_flagc,
                         output int got, output int last);
    got = 0;
    last = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      @(negedge IFCLK);
      if (!SLWR) begin
        got++;
        last = cyc;
      end
    end
    tick();
    if (drop_flagc) FLAGC = 1'b0;
    else            f2h_valid = 1'b0;
  endtask

  typedef struct {
    logic       rst, fb, rdy, fv, fc;
    logic       slrd, slwr, sloe, fds;
    logic [1:0] addr;
    logic       bsy, hv, fr;
  } vec_t;

  vec_t tv[16];
  logic [10:0] act_v, exp_v;

  int got, last, pulses, pk_cyc, d;
  logic [1:0] pk_addr;
  logic pk_slwr;
  int runs_dir[8], runs_len[8];
  int nruns, cur, len, gap, min_gap, ovl, both;
  bit seen;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    // rst fb rdy fv fc | slrd slwr sloe fds addr busy h2fv f2hr
    tv[0]  = '{1,0,0,0,0, 1,1,1,0,2'b00,0,0,0};
    tv[1]  = '{0,1,1,0,0, 1,1,1,0,2'b00,0,0,0};
    tv[2]  = '{0,1,1,0,0, 1,1,0,0,2'b00,1,0,0};
    tv[3]  = '{0,1,1,0,0, 0,1,0,0,2'b00,1,1,0};
    tv[4]  = '{0,1,0,0,0, 1,1,0,0,2'b00,1,0,0};
    tv[5]  = '{0,1,0,1,1, 1,1,0,0,2'b00,1,0,0};
    tv[6]  = '{0,1,0,1,1, 1,1,1,0,2'b00,0,0,0};
    tv[7]  = '{0,1,0,1,1, 1,1,1,1,2'b10,1,0,0};
    tv[8]  = '{0,1,0,1,1, 1,0,1,1,2'b10,1,0,1};
    tv[9]  = '{0,1,0,0,1, 1,1,1,1,2'b10,1,0,0};
    tv[10] = '{0,1,1,1,1, 1,1,1,0,2'b00,0,0,0};
    tv[11] = '{0,1,1,1,1, 1,1,0,0,2'b00,1,0,0};
    tv[12] = '{1,1,1,1,1, 0,1,0,0,2'b00,1,1,0};
    tv[13] = '{1,1,1,1,1, 1,1,1,0,2'b00,0,0,0};
    tv[14] = '{0,1,1,1,1, 1,1,1,0,2'b00,0,0,0};
    tv[15] = '{0,1,1,1,1, 1,1,0,0,2'b00,1,0,0};

    do_reset();
    RST = 1'b1;
    for (int i = 0; i < 16; i++) begin
      RST = tv[i].rst; FLAGB = tv[i].fb; h2f_ready = tv[i].rdy;
      f2h_valid = tv[i].fv; FLAGC = tv[i].fc;
      @(negedge IFCLK);
      act_v = {SLRD, SLWR, SLOE, FDS, ADDR, busy, h2f_valid, f2h_ready,
               PKTEND, 1'b0};
      exp_v = {tv[i].slrd, tv[i].slwr, tv[i].sloe, tv[i].fds, tv[i].addr,
               tv[i].bsy, tv[i].hv, tv[i].fr, 1'b1, 1'b0};
      chk($sformatf("vec%0d", i), 32'(act_v), 32'(exp_v));
      tick();
    end

    // 64-word read burst, one IDLE cycle, then a fresh grant
    do_reset();
    FLAGB = 1; h2f_ready = 1;
    @(negedge IFCLK);
    chk("rd_idle_busy", 32'(busy), 0);
    tick();
    @(negedge IFCLK);
    chk("rd_setup_sloe", 32'({busy, SLOE, SLRD, FDS}), 32'(4'b1010));
    for (int k = 0; k < 64; k++) begin
      tick();
      FDI = 8'(k);
      @(negedge IFCLK);
      chk($sformatf("rd_strobe%0d", k), 32'({SLRD, h2f_valid}), 32'(2'b01));
      chk($sformatf("rd_data%0d", k), 32'(h2f_data), k);
    end
    tick();
    @(negedge IFCLK);
    chk("rd_burst_end", 32'({busy, SLRD}), 32'(2'b01));
    tick();
    @(negedge IFCLK);
    chk("rd_regrant", 32'({busy, SLOE, SLRD}), 32'(3'b101));

    // both directions requesting: round-robin bursts
    do_reset();
    FLAGB = 1; h2f_ready = 1; f2h_valid = 1; FLAGC = 1;
    for (int k = 0; k < 8; k++) begin runs_dir[k] = 0; runs_len[k] = 0; end
    nruns = 0; cur = 0; len = 0; gap = 0; min_gap = 1000;
    ovl = 0; both = 0; seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge IFCLK);
      if (!SLOE && FDS) ovl++;
      if (!SLRD && !SLWR) both++;
      d = !SLRD ? 1 : (!SLWR ? 2 : 0);
      if (d != cur) begin
        if (cur != 0 && nruns < 8) begin
          runs_dir[nruns] = cur;
          runs_len[nruns] = len;
          nruns++;
        end
        if (d != 0 && seen && gap < min_gap) min_gap = gap;
        len = 0;
        gap = 0;
      end
      if (d != 0) begin len++; seen = 1; end
      else gap++;
      cur = d;
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_dir%0d", k), runs_dir[k], (k % 2 == 0) ? 1 : 2);
      chk($sformatf("rr_len%0d", k), runs_len[k], 64);
    end
    chk("rr_min_gap", min_gap, 2);
    chk("rr_fds_sloe_overlap", ovl, 0);
    chk("rr_both_strobes", both, 0);

    // 10-byte short packet, then idle
    do_reset();
    FLAGC = 1; f2h_valid = 1;
    write_n(10, 40, 0, got, last);
    chk("to_wr_count", got, 10);
    pulses = 0; pk_cyc = 0; pk_addr = 2'b00; pk_slwr = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge IFCLK);
      if (!PKTEND) begin
        pulses++;
        if (pulses == 1) begin
          pk_cyc = cyc; pk_addr = ADDR; pk_slwr = SLWR;
        end
      end
    end
`ifdef FX2_SCHED_PKTEND_EN
    chk("to_pktend_pulses", pulses, 1);
    chk("to_pktend_addr", 32'(pk_addr), 2);
    chk("to_pktend_slwr", 32'(pk_slwr), 1);
    d = pk_cyc - last;
    checks++;
    if (d < 1000 || d > 1004) begin
      errors++;
      $display("FAIL to_pktend_delay: got %0d cycles expected 1000..1004", d);
    end
`else
    chk("to_pktend_absent", pulses, 0);
`endif

    // a full 512-byte packet auto-commits, no PKTEND
    do_reset();
    FLAGC = 1; f2h_valid = 1;
    write_n(512, 1000, 0, got, last);
    chk("wrap_wr_count", got, 512);
    pulses = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge IFCLK);
      if (!PKTEND) pulses++;
    end
    chk("wrap_no_pktend", pulses, 0);

    // FLAGC drops on byte 20
    do_reset();
    FLAGC = 1; f2h_valid = 1; f2h_data = 8'h5A;
    write_n(19, 40, 1, got, last);
    chk("fc_wr_count", got, 19);
    @(negedge IFCLK);
    chk("fc_drop_cycle", 32'({SLWR, f2h_ready, busy}), 32'(3'b101));
    tick();
    @(negedge IFCLK);
    chk("fc_idle", 32'({busy, SLWR}), 32'(2'b01));
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge IFCLK);
      if (!SLWR || busy) pulses++;
    end
    chk("fc_quiet", pulses, 0);
    tick();
    FLAGC = 1;
    @(negedge IFCLK);
    chk("fc_resume_idle", 32'(busy), 0);
    tick();
    @(negedge IFCLK);
    chk("fc_wr_setup", 32'({busy, ADDR, FDS, SLWR}), 32'(5'b11011));
    tick();
    @(negedge IFCLK);
    chk("fc_write", 32'({SLWR, f2h_ready}), 32'(2'b01));
    chk("fc_fdo", 32'(FDO), 32'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
